display_scan_ctrl: RTL

Time-multiplexing scheduler for the six-digit seven-segment display of the digital clock. It walks the digit position 0..5 at a programmable dwell rate, presents the matching BCD digit and a 4-bit position code to the downstream position decoder, and inserts blanking guard intervals between digits. It also applies per-digit blinking for time-set mode and optional leading-zero suppression on the hours-tens digit. It sits between the timekeeping counters and the position/segment decoders.

---
 rtl/display_scan_ctrl_pkg.sv | 6 +
 rtl/display_scan_ctrl_if.sv | 14 +
 rtl/display_scan_ctrl_blink_gen.sv | 29 ++
 rtl/display_scan_ctrl.sv | 94 +++++++++
 4 files changed

// File: rtl/display_scan_ctrl_pkg.sv
// display_scan_ctrl_pkg: shared constants and state encoding for the display scan controller
package display_scan_ctrl_pkg;
  localparam int NUM_DIGITS = 6;
  localparam logic [3:0] POS_NONE = 4'hF;
  typedef enum logic [1:0] {IDLE = 2'd0, SHOW = 2'd1, GUARD = 2'd2} state_e;
endpackage

// File: rtl/display_scan_ctrl_if.sv
// display_scan_ctrl_if: digit inputs and decoder-side outputs of the scan controller
interface display_scan_ctrl_if;
  import display_scan_ctrl_pkg::*;
  logic                    enable;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic                    lz_suppress;
  logic [3:0]              bcd_pos;
  logic [3:0]              digit_bcd;
  logic                    blank;
  logic                    frame_done;
  modport master (output enable, digits, blink_mask, lz_suppress, input bcd_pos, digit_bcd, blank, frame_done);
  modport slave (input enable, digits, blink_mask, lz_suppress, output bcd_pos, digit_bcd, blank, frame_done);
endinterface

// File: rtl/display_scan_ctrl_blink_gen.sv
// blink_gen: counts completed frames and toggles the blink phase every BLINK_FRAMES frames
module blink_gen #(
  parameter int BLINK_FRAMES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic frame_done,
  output logic blink_phase
);
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  logic [FW-1:0] cnt_q, cnt_d;
  logic phase_q, phase_d, at_end;
  always_comb begin
    at_end = cnt_q == FW'(BLINK_FRAMES - 1);
    cnt_d = clear ? '0 : frame_done ? (at_end ? '0 : cnt_q + 1'b1) : cnt_q;
    phase_d = clear ? 1'b0 : phase_q ^ (frame_done & at_end);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      phase_q <= phase_d;
    end
  end
  assign blink_phase = phase_q;
endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: six-digit display scan scheduler with guard blanking, blinking and leading-zero suppression
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int GUARD_CYCLES = 50,
  parameter int BLINK_FRAMES = 64
) (
  input logic clk,
  input logic rst,
  display_scan_ctrl_if.slave bus
);
  localparam int MAXC = SCAN_DIV > GUARD_CYCLES ? SCAN_DIV : GUARD_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [2:0] LAST_POS = 3'(NUM_DIGITS - 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] pos_q, pos_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0] mask_q, mask_d;
  logic [3:0] bcd_pos_q, bcd_pos_d, digit_bcd_q, digit_bcd_d, nib;
  logic blank_q, blank_d, frame_done_q, frame_done_d;
  logic last_show, last_guard, advance, wrap, show_blank, blink_phase;
  blink_gen #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
    .clk(clk),
    .rst(rst),
    .clear(!bus.enable),
    .frame_done(wrap),
    .blink_phase(blink_phase)
  );
  always_comb begin
    nib = digits_q[{pos_q, 2'b00} +: 4];
    last_show = cnt_q == CW'(SCAN_DIV - 1);
    last_guard = cnt_q == CW'(GUARD_CYCLES - 1);
    advance = (state_q == SHOW && last_show && GUARD_CYCLES == 0) || (state_q == GUARD && last_guard);
    wrap = advance && pos_q == LAST_POS;
    show_blank = (blink_phase & mask_q[pos_q]) | (bus.lz_suppress & (pos_q == LAST_POS) & (nib == 4'd0));
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    pos_d = pos_q;
    digits_d = digits_q;
    mask_d = mask_q;
    if (!bus.enable) begin
      state_d = IDLE;
      cnt_d = '0;
      pos_d = '0;
    end else if (state_q == IDLE || wrap) begin
      state_d = SHOW;
      cnt_d = '0;
      pos_d = '0;
      digits_d = bus.digits;
      mask_d = bus.blink_mask;
    end else if (advance) begin
      state_d = SHOW;
      cnt_d = '0;
      pos_d = pos_q + 1'b1;
    end else if (state_q == SHOW && last_show) begin
      state_d = GUARD;
      cnt_d = '0;
    end
    // outputs reflect the current state one edge later; disable takes effect immediately
    frame_done_d = bus.enable & wrap;
    digit_bcd_d = (!bus.enable || state_q == IDLE) ? 4'd0 : state_q == SHOW ? nib : digit_bcd_q;
    blank_d = !(bus.enable && state_q == SHOW) || show_blank;
    bcd_pos_d = blank_d ? POS_NONE : {1'b0, pos_q};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      pos_q <= '0;
      digits_q <= '0;
      mask_q <= '0;
      bcd_pos_q <= POS_NONE;
      digit_bcd_q <= 4'd0;
      blank_q <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pos_q <= pos_d;
      digits_q <= digits_d;
      mask_q <= mask_d;
      bcd_pos_q <= bcd_pos_d;
      digit_bcd_q <= digit_bcd_d;
      blank_q <= blank_d;
      frame_done_q <= frame_done_d;
    end
  end
  assign bus.bcd_pos = bcd_pos_q;
  assign bus.digit_bcd = digit_bcd_q;
  assign bus.blank = blank_q;
  assign bus.frame_done = frame_done_q;
endmodule
